// File: rtl/axis_echo_pkg.sv
// Shared types and constants for the axis_echo stereo echo stage.
package axis_echo_pkg;

    // Default sample width of the audio chain.
    localparam int SAMPLE_W = 24;

    // Feedback gain is sw/16, applied as a multiply followed by this shift.
    localparam int GAIN_SHIFT = 4;

    typedef enum logic [2:0] {
        ST_CLEAR = 3'd0,
        ST_RECV  = 3'd1,
        ST_READ  = 3'd2,
        ST_MIX   = 3'd3,
        ST_SEND  = 3'd4
    } state_e;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef struct packed {
        sample_t l;
        sample_t r;
    } frame_t;

    // Largest and smallest representable sample at an arbitrary width.
    function automatic logic signed [63:0] sat_max_w(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min_w(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    localparam sample_t SAMPLE_MAX = sample_t'(sat_max_w(SAMPLE_W));
    localparam sample_t SAMPLE_MIN = sample_t'(sat_min_w(SAMPLE_W));

endpackage

// File: rtl/axis_echo_ram.sv
// Single-port synchronous delay-line RAM: 1-cycle read latency, write-first,
// no reset so it maps onto block RAM.
module axis_echo_ram #(
    parameter int DATA_W = 48,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Memory array write and registered, write-first read port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
            rdata_q       <= wdata_i;
        end else begin
            rdata_q       <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/axis_echo.sv
// Stereo AXI-Stream echo: y = x + ((d * sw) >>> 4), d being the frame output
// DELAY_FRAMES frames earlier. Define AXIS_ECHO_SATURATE_EN to clamp y to the
// sample range; otherwise y wraps to DATA_WIDTH bits.
module axis_echo
    import axis_echo_pkg::*;
#(
    parameter int DATA_WIDTH   = 24,
    parameter int ADDR_WIDTH   = 12,
    parameter int DELAY_FRAMES = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            sw,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last
);

    localparam int SUM_W = DATA_WIDTH + 5;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DELAY_FRAMES - 1);

`ifdef AXIS_ECHO_SATURATE_EN
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(sat_max_w(DATA_WIDTH));
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(sat_min_w(DATA_WIDTH));
`endif

    // Reduce the wide mix result to a sample.
    function automatic logic signed [DATA_WIDTH-1:0] reduce_sample(input logic signed [SUM_W-1:0] v);
`ifdef AXIS_ECHO_SATURATE_EN
        logic signed [DATA_WIDTH-1:0] r;
        if (v > SAT_MAX) begin
            r = SAT_MAX[DATA_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            r = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            r = v[DATA_WIDTH-1:0];
        end
        return r;
`else
        return DATA_WIDTH'(v);
`endif
    endfunction

    state_e                         state_q, state_d;
    logic [ADDR_WIDTH-1:0]          ptr_q, ptr_d;
    logic [ADDR_WIDTH-1:0]          clr_q, clr_d;
    logic [3:0]                     sw_s1_q, sw_s2_q, sw_s3_q;
    logic signed [DATA_WIDTH-1:0]   x_l_q, x_l_d, x_r_q, x_r_d;
    logic signed [SUM_W-1:0]        echo_l_q, echo_l_d, echo_r_q, echo_r_d;
    logic                           mix_stage_q, mix_stage_d;
    logic signed [DATA_WIDTH-1:0]   y_r_q, y_r_d;
    logic                           s_ready_q, s_ready_d;
    logic                           m_valid_q, m_valid_d;
    logic                           m_last_q, m_last_d;
    logic [DATA_WIDTH-1:0]          m_data_q, m_data_d;

    logic                           ram_we_s;
    logic [ADDR_WIDTH-1:0]          ram_addr_s;
    logic [2*DATA_WIDTH-1:0]        ram_wdata_s;
    logic [2*DATA_WIDTH-1:0]        ram_rdata_s;

    logic signed [SUM_W-1:0]        gain_s;
    logic signed [SUM_W-1:0]        d_l_s, d_r_s;
    logic signed [SUM_W-1:0]        scaled_l_s, scaled_r_s;
    logic signed [DATA_WIDTH-1:0]   y_l_s, y_r_s;

    axis_echo_ram #(
        .DATA_W (2 * DATA_WIDTH),
        .ADDR_W (ADDR_WIDTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .rdata_o (ram_rdata_s)
    );

    // Mix datapath: the delayed sample times gain is registered in the first
    // MIX cycle, then added to the dry sample in the second.
    always_comb begin
        gain_s     = SUM_W'({1'b0, sw_s3_q});
        d_l_s      = SUM_W'($signed(ram_rdata_s[2*DATA_WIDTH-1:DATA_WIDTH]));
        d_r_s      = SUM_W'($signed(ram_rdata_s[DATA_WIDTH-1:0]));
        scaled_l_s = (d_l_s * gain_s) >>> GAIN_SHIFT;
        scaled_r_s = (d_r_s * gain_s) >>> GAIN_SHIFT;
        y_l_s      = reduce_sample(SUM_W'(x_l_q) + echo_l_q);
        y_r_s      = reduce_sample(SUM_W'(x_r_q) + echo_r_q);
    end

    // Next-state, RAM port and AXIS output decode.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        clr_d       = clr_q;
        x_l_d       = x_l_q;
        x_r_d       = x_r_q;
        echo_l_d    = echo_l_q;
        echo_r_d    = echo_r_q;
        mix_stage_d = mix_stage_q;
        y_r_d       = y_r_q;
        s_ready_d   = s_ready_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        m_data_d    = m_data_q;
        ram_we_s    = 1'b0;
        ram_addr_s  = ptr_q;
        ram_wdata_s = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_we_s   = 1'b1;
                ram_addr_s = clr_q;
                if (clr_q == LAST_ADDR) begin
                    clr_d     = '0;
                    state_d   = ST_RECV;
                    s_ready_d = 1'b1;
                end else begin
                    clr_d = clr_q + ADDR_WIDTH'(1);
                end
            end
            ST_RECV: begin
                if (s_axis_valid && s_ready_q) begin
                    if (s_axis_last) begin
                        x_r_d     = s_axis_data;
                        state_d   = ST_READ;
                        s_ready_d = 1'b0;
                    end else begin
                        x_l_d = s_axis_data;
                    end
                end else begin
                    state_d = ST_RECV;
                end
            end
            ST_READ: begin
                ram_addr_s  = ptr_q;
                mix_stage_d = 1'b0;
                state_d     = ST_MIX;
            end
            ST_MIX: begin
                if (!mix_stage_q) begin
                    echo_l_d    = scaled_l_s;
                    echo_r_d    = scaled_r_s;
                    mix_stage_d = 1'b1;
                end else begin
                    // Write-back and output load happen on the SEND entry edge.
                    ram_we_s    = 1'b1;
                    ram_addr_s  = ptr_q;
                    ram_wdata_s = {y_l_s, y_r_s};
                    ptr_d       = (ptr_q == LAST_ADDR) ? '0 : ptr_q + ADDR_WIDTH'(1);
                    y_r_d       = y_r_s;
                    m_valid_d   = 1'b1;
                    m_last_d    = 1'b0;
                    m_data_d    = y_l_s;
                    mix_stage_d = 1'b0;
                    state_d     = ST_SEND;
                end
            end
            ST_SEND: begin
                if (m_axis_ready) begin
                    if (!m_last_q) begin
                        m_last_d = 1'b1;
                        m_data_d = y_r_q;
                    end else begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        m_data_d  = '0;
                        s_ready_d = 1'b1;
                        state_d   = ST_RECV;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_d     = '0;
                s_ready_d = 1'b0;
                m_valid_d = 1'b0;
                m_last_d  = 1'b0;
                m_data_d  = '0;
            end
        endcase
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            clr_q       <= '0;
            sw_s1_q     <= 4'd0;
            sw_s2_q     <= 4'd0;
            sw_s3_q     <= 4'd0;
            x_l_q       <= '0;
            x_r_q       <= '0;
            echo_l_q    <= '0;
            echo_r_q    <= '0;
            mix_stage_q <= 1'b0;
            y_r_q       <= '0;
            s_ready_q   <= 1'b0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            m_data_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            clr_q       <= clr_d;
            sw_s1_q     <= sw;
            sw_s2_q     <= sw_s1_q;
            sw_s3_q     <= sw_s2_q;
            x_l_q       <= x_l_d;
            x_r_q       <= x_r_d;
            echo_l_q    <= echo_l_d;
            echo_r_q    <= echo_r_d;
            mix_stage_q <= mix_stage_d;
            y_r_q       <= y_r_d;
            s_ready_q   <= s_ready_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            m_data_q    <= m_data_d;
        end
    end

    assign s_axis_ready = s_ready_q;
    assign m_axis_valid = m_valid_q;
    assign m_axis_last  = m_last_q;
    assign m_axis_data  = m_data_q;

endmodule

// File: tb/tb_axis_echo.sv
// Scoreboard bench for axis_echo with a 16-frame delay line.
module tb_axis_echo;

    localparam int DW = 24;
    localparam int AW = 4;
    localparam int DF = 16;

    logic          clk;
    logic          reset;
    logic [3:0]    sw;
    logic [DW-1:0] s_axis_data;
    logic          s_axis_valid;
    logic          s_axis_ready;
    logic          s_axis_last;
    logic [DW-1:0] m_axis_data;
    logic          m_axis_valid;
    logic          m_axis_ready;
    logic          m_axis_last;

    axis_echo #(
        .DATA_WIDTH   (DW),
        .ADDR_WIDTH   (AW),
        .DELAY_FRAMES (DF)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sw           (sw),
        .s_axis_data  (s_axis_data),
        .s_axis_valid (s_axis_valid),
        .s_axis_ready (s_axis_ready),
        .s_axis_last  (s_axis_last),
        .m_axis_data  (m_axis_data),
        .m_axis_valid (m_axis_valid),
        .m_axis_ready (m_axis_ready),
        .m_axis_last  (m_axis_last)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } exp_t;

    exp_t          sb[$];
    int            n_cmp  = 0;
    int            n_fail = 0;
    logic [DW-1:0] prev_data  = '0;
    logic          prev_last  = 1'b0;
    logic          prev_stall = 1'b0;

`ifdef AXIS_ECHO_SATURATE_EN
    localparam logic [DW-1:0] SAT_FRAME16 = axis_echo_pkg::SAMPLE_MAX;
`else
    localparam logic [DW-1:0] SAT_FRAME16 = 24'hD90000;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp_v, $time);
        end
    endfunction

    // Monitor: compares each master transfer against the scoreboard, checks
    // idle data is zero and that a stalled output holds steady.
    always @(negedge clk) begin
        if (!reset) begin
            if (m_axis_valid && m_axis_ready) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_output: got %h, expected nothing", m_axis_data);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("out_data", 32'(m_axis_data), 32'(e.data));
                    check("out_last", 32'(m_axis_last), 32'(e.last));
                end
            end
            if (!m_axis_valid) begin
                check("idle_data_zero", 32'(m_axis_data), 32'd0);
            end
            if (prev_stall && m_axis_valid) begin
                check("stall_data_hold", 32'(m_axis_data), 32'(prev_data));
                check("stall_last_hold", 32'(m_axis_last), 32'(prev_last));
            end
        end
        prev_stall <= m_axis_valid && !m_axis_ready && !reset;
        prev_data  <= m_axis_data;
        prev_last  <= m_axis_last;
    end

    task automatic send_word(input logic [DW-1:0] d, input logic l);
        int guard;
        bit done;
        guard = 0;
        done  = 1'b0;
        s_axis_data  = d;
        s_axis_last  = l;
        s_axis_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            guard++;
            if (s_axis_ready) begin
                done = 1'b1;
            end else if (guard > 400) begin
                n_cmp++;
                n_fail++;
                $display("FAIL slave_accept_timeout: ready stuck at %b, expected 1", s_axis_ready);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        s_axis_valid = 1'b0;
    endtask

    task automatic frame(input logic [DW-1:0] in_l, input logic [DW-1:0] in_r,
                         input logic [DW-1:0] exp_l, input logic [DW-1:0] exp_r);
        sb.push_back('{exp_l, 1'b0});
        sb.push_back('{exp_r, 1'b1});
        send_word(in_l, 1'b0);
        send_word(in_r, 1'b1);
    endtask

    // Assert reset, release it at a falling edge and check the CLEAR window.
    task automatic do_reset();
        reset = 1'b1;
        sb.delete();
        s_axis_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i <= DF; i++) begin
            if (i > 0) @(negedge clk);
            check("clear_s_ready", 32'(s_axis_ready), (i < DF) ? 32'd0 : 32'd1);
            check("clear_m_valid", 32'(m_axis_valid), 32'd0);
            check("clear_m_data", 32'(m_axis_data), 32'd0);
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (sb.size() != 0 && g < 1000) begin
            @(posedge clk);
            g++;
        end
        check("drain_pending", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
    endtask

    task automatic wait_m_valid();
        int g;
        g = 0;
        while (!m_axis_valid && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("m_valid_seen", 32'(m_axis_valid), 32'd1);
    endtask

    initial begin
        int lat;
        reset        = 1'b1;
        sw           = 4'd0;
        s_axis_data  = '0;
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
        m_axis_ready = 1'b1;

        // Reset and pass-through with latency measurement.
        do_reset();
        sb.push_back('{24'h100000, 1'b0});
        sb.push_back('{24'hF00000, 1'b1});
        send_word(24'h100000, 1'b0);
        send_word(24'hF00000, 1'b1);
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            #1;
            if (m_axis_valid && lat == 0) lat = k;
        end
        check("valid_latency", 32'(lat), 32'd3);
        drain();

        // Impulse at g = 8/16: echoes at frames 16 and 32.
        sw = 4'd8;
        do_reset();
        frame(24'h200000, 24'h200000, 24'h200000, 24'h200000);
        for (int i = 1; i <= 33; i++) begin
            if (i == 16)      frame(24'h0, 24'h0, 24'h100000, 24'h100000);
            else if (i == 32) frame(24'h0, 24'h0, 24'h080000, 24'h080000);
            else              frame(24'h0, 24'h0, 24'h0, 24'h0);
        end
        drain();

        // Backpressure on the first frame; the echo position proves one write.
        do_reset();
        m_axis_ready = 1'b0;
        frame(24'h200000, 24'h200000, 24'h200000, 24'h200000);
        wait_m_valid();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_s_ready_low", 32'(s_axis_ready), 32'd0);
            check("bp_m_valid_high", 32'(m_axis_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        m_axis_ready = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            if (i == 16) frame(24'h0, 24'h0, 24'h100000, 24'h100000);
            else         frame(24'h0, 24'h0, 24'h0, 24'h0);
        end
        drain();

        // Large feedback: frame 16 exceeds the sample range.
        sw = 4'd15;
        do_reset();
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) frame(24'h700000, 24'h700000, 24'h700000, 24'h700000);
            else        frame(24'h700000, 24'h700000, SAT_FRAME16, SAT_FRAME16);
        end
        drain();

        // Reset during SEND discards the frame and restarts CLEAR.
        sw = 4'd8;
        do_reset();
        m_axis_ready = 1'b0;
        send_word(24'h400000, 1'b0);
        send_word(24'h400000, 1'b1);
        wait_m_valid();
        #2;
        reset = 1'b1;
        #1;
        check("midrst_m_valid", 32'(m_axis_valid), 32'd0);
        check("midrst_m_last", 32'(m_axis_last), 32'd0);
        check("midrst_m_data", 32'(m_axis_data), 32'd0);
        check("midrst_s_ready", 32'(s_axis_ready), 32'd0);
        m_axis_ready = 1'b1;
        do_reset();
        frame(24'h200000, 24'h200000, 24'h200000, 24'h200000);
        for (int i = 1; i <= 17; i++) begin
            if (i == 16) frame(24'h0, 24'h0, 24'h100000, 24'h100000);
            else         frame(24'h0, 24'h0, 24'h0, 24'h0);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/axis_echo.md
# axis_echo

Stereo echo/delay stage on the AXI-Stream audio path, placed directly upstream of the volume controller. Each 2-word packet (left word `last`=0, right word `last`=1) is summed with a feedback-scaled copy of the frame output DELAY_FRAMES frames earlier. The result goes out on the master interface and is also written back into an on-chip circular buffer. Gain comes from the 4 board switches. The block uses the same packet-blocking handshake style as the rest of the audio chain.

## Interface
- `DATA_WIDTH`, 24: signed sample width.
- `ADDR_WIDTH`, 12: buffer address width.
- `DELAY_FRAMES`, 4096: echo delay in frames; must be ≤ 2**ADDR_WIDTH.
- `clk`  in  1: system clock; all logic is on its rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `sw`  in  4: feedback gain g = sw/16. Synchronised internally through a 3-flop chain.
- `s_axis_data`  in  DATA_WIDTH: input sample, two's complement.
- `s_axis_valid`  in  1: slave valid.
- `s_axis_ready`  out  1: slave ready.
- `s_axis_last`  in  1: 0 = left word, 1 = right word.
- `m_axis_data`  out  DATA_WIDTH: output sample, registered. Reads 0 whenever `m_axis_valid`=0.
- `m_axis_valid`  out  1: master valid.
- `m_axis_ready`  in  1: master ready.
- `m_axis_last`  out  1: 0 while the left word is presented, 1 while the right word is presented.

## Operation
- Reset values: `s_axis_ready`=0, `m_axis_valid`=0, `m_axis_last`=0, `m_axis_data`=0, write pointer=0, FSM in CLEAR.
- The buffer holds DELAY_FRAMES entries of {L,R}, 2*DATA_WIDTH bits each.
- FSM states:
  - CLEAR: writes 0 to addresses 0..DELAY_FRAMES-1, one per cycle; moves to RECV after the last address.
  - RECV: `s_axis_ready`=1.
    - Accepted word with `last`=0 is stored as L; a repeated `last`=0 overwrites L.
    - Accepted word with `last`=1 is stored as R; the FSM moves to READ and `s_axis_ready` falls on the same edge.
  - READ: issues a read at the pointer address.
  - MIX: for each channel, y = x + ((d * g) >>> 4), where d is the delayed sample read back. Arithmetic is signed, DATA_WIDTH+5 bits internally, then reduced to DATA_WIDTH.
  - SEND: present y_L, then y_R.
    - {y_L,y_R} is written to the pointer address on the SEND entry edge.
    - The pointer then increments, wrapping from DELAY_FRAMES-1 to 0.
    - After the right word is accepted on the master side, the FSM returns to RECV.
- g=0 gives a pure pass-through (y = x).
- The maximum gain of 15/16 keeps feedback bounded-decaying.

## Timing
- Throughput is one frame in flight; the slave interface is blocked from the right-word accept until the master right-word accept.
- `m_axis_valid` rises on the 3rd rising edge after the edge that accepts the slave right word.
- The buffer write occurs on that same edge, exactly once per frame, independent of backpressure.
- Output ordering:
  - `m_axis_last`=0 until the left word transfers, then 1.
  - On the right-word transfer: `m_axis_valid`→0 and `m_axis_last`→0, and `s_axis_ready`→1 on the same edge.
- Backpressure: `m_axis_data` and `m_axis_last` hold steady while `m_axis_valid`=1 and `m_axis_ready`=0.
- The buffer has 1-cycle read latency. Read and write never target the same address in the same cycle.
- CLEAR lasts exactly DELAY_FRAMES cycles after `reset` deasserts; `s_axis_ready` first rises on the next edge.
- Reset mid-operation: all outputs return to their reset values immediately (asynchronously). Any in-flight frame is discarded, and CLEAR restarts from address 0.
- `sw` changes take effect 3 cycles later. The value used for a frame is the one sampled in MIX.

## Configuration
- `AXIS_ECHO_SATURATE_EN` defined: y clamps to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], i.e. 0x800000..0x7FFFFF at 24 bits.
- `AXIS_ECHO_SATURATE_EN` undefined: y is the low DATA_WIDTH bits of the sum (two's-complement wrap). This saves the clamp logic.

## Structure
- Package `axis_echo_pkg` holds:
  - the FSM state enum (CLEAR, RECV, READ, MIX, SEND);
  - the frame typedef {L,R};
  - sample min/max constants;
  - the gain shift constant (4).
- One sub-module, `axis_echo_ram`:
  - single-port synchronous RAM, 2*DATA_WIDTH × 2**ADDR_WIDTH;
  - 1-cycle read latency, write-first, no reset;
  - infers block RAM.
- The top level holds the FSM, pointer, switch synchroniser, MIX datapath, and AXIS registers.

## Test plan
Bench uses DELAY_FRAMES=16 and `m_axis_ready`=1 unless stated.
- Reset: deassert `reset` → `s_axis_ready`=0 for exactly 16 cycles, then 1; `m_axis_valid`=0 and `m_axis_data`=0 throughout.
- Pass-through: sw=0, send L=0x100000, R=0xF00000 → output L=0x100000, R=0xF00000; `m_axis_valid` rises on the 3rd edge after the R accept.
- Impulse: sw=8, send frame0 L=R=0x200000 followed by zero frames → frame16 output 0x100000, frame32 0x080000, all others 0.
- Saturation: sw=15, constant L=R=0x700000 → frame16 output 0x7FFFFF with the macro defined, 0xD90000 without it.
- Backpressure: hold `m_axis_ready`=0 for 10 cycles during SEND → data stable, `s_axis_ready`=0, pointer advanced once, single buffer write.
- Mid-operation reset: assert `reset` during SEND → `m_axis_valid`=0 immediately; CLEAR re-runs for 16 cycles; the next impulse echoes only from the new data.
